// File: rtl/latch_bank_sequencer.sv
// latch_bank_sequencer
// Serialises single-bit writes from two requesters into a bank of eight
// transparent D latches that share one data line and have one-hot gates.
// Each write runs SETUP (data settles, gates closed), PULSE (one gate open
// for PULSE_W cycles) and HOLD (gates closed, ack). Requesters are served
// round-robin. Every output comes straight from a flop.
//
// Optional build macro: LATCH_CHECK_EN
//   defined   : in HOLD, q_in[captured addr] is compared with the captured
//               data; a mismatch sets the sticky err flag until reset.
//   undefined : q_in is ignored and err is tied low.
//
// state | meaning
// IDLE  | no write in flight, waiting for a request
// SETUP | lat_d driven with captured data, all gates closed
// PULSE | gate of captured address open for PULSE_W cycles
// HOLD  | gates closed, ack of the granted requester high
module latch_bank_sequencer #(
    parameter int unsigned PULSE_W = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req0,
    input  logic [2:0] addr0,
    input  logic       d0,
    output logic       ack0,
    input  logic       req1,
    input  logic [2:0] addr1,
    input  logic       d1,
    output logic       ack1,
    output logic       lat_d,
    output logic [7:0] lat_c,
    input  logic [7:0] q_in,
    output logic       busy,
    output logic       err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        PULSE = 2'd2,
        HOLD  = 2'd3
    } state_t;

    // Pulse timer is a down-counter; PULSE ends at terminal count zero.
    localparam logic [3:0] CNT_LOAD = 4'(PULSE_W - 1);

    state_t     state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [2:0] addr_q, addr_d;
    logic       dat_q, dat_d;
    logic       who_q, who_d;     // requester owning the write in flight
    logic       ptr_q, ptr_d;     // requester granted most recently
    logic       lat_d_q, lat_d_d;
    logic [7:0] lat_c_q, lat_c_d;
    logic       ack0_q, ack0_d;
    logic       ack1_q, ack1_d;
    logic       busy_q, busy_d;
    logic       gnt1;
`ifdef LATCH_CHECK_EN
    logic       err_q, err_d;
`endif

    // On a tie the requester not served last wins; a lone request always wins.
    assign gnt1 = req1 && (!req0 || !ptr_q);

    // Next-state and next-output computation for the write sequence.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        dat_d   = dat_q;
        who_d   = who_q;
        ptr_d   = ptr_q;
        lat_d_d = lat_d_q;
        lat_c_d = lat_c_q;
        ack0_d  = 1'b0;
        ack1_d  = 1'b0;
        busy_d  = busy_q;
`ifdef LATCH_CHECK_EN
        err_d   = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (req0 || req1) begin
                    who_d   = gnt1;
                    ptr_d   = gnt1;
                    addr_d  = gnt1 ? addr1 : addr0;
                    dat_d   = gnt1 ? d1 : d0;
                    lat_d_d = gnt1 ? d1 : d0;
                    lat_c_d = '0;
                    busy_d  = 1'b1;
                    state_d = SETUP;
                end
            end
            SETUP: begin
                lat_c_d = 8'b1 << addr_q;
                cnt_d   = CNT_LOAD;
                state_d = PULSE;
            end
            PULSE: begin
                if (cnt_q == 4'd0) begin
                    lat_c_d = '0;
                    ack0_d  = !who_q;
                    ack1_d  = who_q;
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            HOLD: begin
`ifdef LATCH_CHECK_EN
                // Latch has been closed for a full cycle; its q is settled.
                if (q_in[addr_q] != dat_q) begin
                    err_d = 1'b1;
                end
`endif
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                lat_c_d = '0;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears the latch gates at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            addr_q  <= '0;
            dat_q   <= 1'b0;
            who_q   <= 1'b0;
            ptr_q   <= 1'b1;
            lat_d_q <= 1'b0;
            lat_c_q <= '0;
            ack0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            busy_q  <= 1'b0;
`ifdef LATCH_CHECK_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            dat_q   <= dat_d;
            who_q   <= who_d;
            ptr_q   <= ptr_d;
            lat_d_q <= lat_d_d;
            lat_c_q <= lat_c_d;
            ack0_q  <= ack0_d;
            ack1_q  <= ack1_d;
            busy_q  <= busy_d;
`ifdef LATCH_CHECK_EN
            err_q   <= err_d;
`endif
        end
    end

    assign lat_d = lat_d_q;
    assign lat_c = lat_c_q;
    assign ack0  = ack0_q;
    assign ack1  = ack1_q;
    assign busy  = busy_q;

`ifdef LATCH_CHECK_EN
    assign err = err_q;
`else
    logic unused_q_in;
    assign unused_q_in = ^q_in;
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_latch_bank_sequencer.sv
// Bench for latch_bank_sequencer: reset checks, hand-written corner
// sequences, a table of arbitration scenarios, and a random run checked
// against a transaction-timeline model of the write protocol.
module tb_latch_bank_sequencer;

    localparam int PW = 2;
`ifdef LATCH_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0 = 1'b0, d0 = 1'b0, req1 = 1'b0, d1 = 1'b0;
    logic [2:0] addr0 = '0, addr1 = '0;
    logic       ack0, ack1, lat_d, busy, err;
    logic [7:0] lat_c, q_in;
    logic [7:0] lq = '0;
    logic       stuck3 = 1'b0;

    int n_vec = 0;
    int n_bad = 0;

    latch_bank_sequencer #(.PULSE_W(PW)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0(req0), .addr0(addr0), .d0(d0), .ack0(ack0),
        .req1(req1), .addr1(addr1), .d1(d1), .ack1(ack1),
        .lat_d(lat_d), .lat_c(lat_c), .q_in(q_in),
        .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    // Eight transparent D latches; bit 3 can be forced stuck at 0.
    always @(lat_c or lat_d) begin
        for (int i = 0; i < 8; i++) if (lat_c[i]) lq[i] = lat_d;
    end
    assign q_in = stuck3 ? (lq & 8'hF7) : lq;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req0 = 1'b0;
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    typedef struct {
        logic r0; logic [2:0] a0; logic dd0;
        logic r1; logic [2:0] a1; logic dd1;
        int   n;
        logic w0; logic [7:0] c0; logic ld0;
        logic w1; logic [7:0] c1; logic ld1;
    } vec_t;
    vec_t tbl[5];

    task automatic run_entry(input int idx);
        vec_t e;
        int got = 0;
        logic w[2];
        logic [7:0] c[2];
        logic ld[2];
        int cy[2];
        logic [7:0] seen_c = '0;
        logic seen_d = 1'b0;
        e = tbl[idx];
        req0 = e.r0; addr0 = e.a0; d0 = e.dd0;
        req1 = e.r1; addr1 = e.a1; d1 = e.dd1;
        for (int k = 1; k <= 40 && got < e.n; k++) begin
            @(negedge clk);
            chk($sformatf("tbl%0d_onehot", idx), 32'($countones(lat_c) <= 1), 1);
            if (lat_c != 0) begin
                seen_c = lat_c;
                seen_d = lat_d;
            end
            if (ack0 || ack1) begin
                chk($sformatf("tbl%0d_ack_excl", idx), 32'(ack0 && ack1), 0);
                w[got] = ack1; c[got] = seen_c; ld[got] = seen_d; cy[got] = k;
                got++;
                if (ack0) req0 = 1'b0;
                if (ack1) req1 = 1'b0;
            end
        end
        req0 = 1'b0;
        req1 = 1'b0;
        chk($sformatf("tbl%0d_ack_count", idx), got, e.n);
        if (got >= 1) begin
            chk($sformatf("tbl%0d_first_who", idx), w[0], e.w0);
            chk($sformatf("tbl%0d_first_lat_c", idx), c[0], e.c0);
            chk($sformatf("tbl%0d_first_lat_d", idx), ld[0], e.ld0);
        end
        if (e.n == 2 && got == 2) begin
            chk($sformatf("tbl%0d_second_who", idx), w[1], e.w1);
            chk($sformatf("tbl%0d_second_lat_c", idx), c[1], e.c1);
            chk($sformatf("tbl%0d_second_lat_d", idx), ld[1], e.ld1);
            chk($sformatf("tbl%0d_ack_gap", idx), cy[1] - cy[0], PW + 3);
        end
        if (e.r0) chk($sformatf("tbl%0d_latch0", idx), lq[e.a0], e.dd0);
        if (e.r1) chk($sformatf("tbl%0d_latch1", idx), lq[e.a1], e.dd1);
    endtask

    // Timeline model for the random run: p counts cycles since the grant edge.
    logic       m_active, m_who, m_ptr, m_d, m_latd;
    logic [2:0] m_addr;
    int         m_p;
    logic       pend0, pend1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acks;
        logic old2;
        logic g1;
        logic [7:0] e_latc;

        tbl[0] = '{1'b1, 3'd1, 1'b0, 1'b1, 3'd6, 1'b1, 2, 1'b0, 8'h02, 1'b0, 1'b1, 8'h40, 1'b1};
        tbl[1] = '{1'b0, 3'd0, 1'b0, 1'b1, 3'd2, 1'b1, 1, 1'b1, 8'h04, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[2] = '{1'b1, 3'd7, 1'b1, 1'b1, 3'd0, 1'b0, 2, 1'b0, 8'h80, 1'b1, 1'b1, 8'h01, 1'b0};
        tbl[3] = '{1'b1, 3'd5, 1'b1, 1'b0, 3'd0, 1'b0, 1, 1'b0, 8'h20, 1'b1, 1'b0, 8'h00, 1'b0};
        tbl[4] = '{1'b1, 3'd3, 1'b0, 1'b1, 3'd4, 1'b1, 2, 1'b1, 8'h10, 1'b1, 1'b0, 8'h08, 1'b0};

        // Reset state
        #3;
        chk("rst_lat_c", lat_c, 0);
        chk("rst_lat_d", lat_d, 0);
        chk("rst_ack0", ack0, 0);
        chk("rst_ack1", ack1, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single write to latch 5 with exact cycle timing
        req0 = 1'b1; addr0 = 3'd5; d0 = 1'b1;
        for (int k = 1; k <= PW + 3; k++) begin
            @(negedge clk);
            chk($sformatf("w5_lat_d_k%0d", k), lat_d, 1);
            chk($sformatf("w5_lat_c_k%0d", k), lat_c, (k >= 2 && k <= PW + 1) ? 8'h20 : 8'h00);
            chk($sformatf("w5_ack0_k%0d", k), ack0, 32'(k == PW + 2));
            chk($sformatf("w5_busy_k%0d", k), busy, 32'(k <= PW + 2));
            if (ack0) req0 = 1'b0;
        end
        req0 = 1'b0;
        chk("w5_latch_q5", lq[5], 1);

        // Address/data change and request drop after grant are ignored
        old2 = lq[2];
        acks = 0;
        req0 = 1'b1; addr0 = 3'd6; d0 = 1'b1;
        for (int k = 1; k <= PW + 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                addr0 = 3'd2; d0 = 1'b0; req0 = 1'b0;
            end
            acks += int'(ack0);
            chk($sformatf("mid_lat_c_k%0d", k), lat_c, (k >= 2 && k <= PW + 1) ? 8'h40 : 8'h00);
            chk($sformatf("mid_lat_d_k%0d", k), lat_d, 1);
        end
        chk("mid_ack_count", acks, 1);
        chk("mid_latch_q6", lq[6], 1);
        chk("mid_latch_q2", lq[2], old2);

        // Reset in the middle of PULSE
        req0 = 1'b1; addr0 = 3'd4; d0 = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_lat_c", lat_c, 8'h10);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_lat_c", lat_c, 0);
        chk("abort_busy", busy, 0);
        chk("abort_ack0", ack0, 0);
        chk("abort_err", err, 0);
        chk("abort_lat_d", lat_d, 0);
        req0 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        acks = 0;
        for (int k = 0; k < PW + 5; k++) begin
            @(negedge clk);
            acks += int'(ack0) + int'(ack1);
        end
        chk("abort_no_ack", acks, 0);

        // Readback check against a latch with bit 3 stuck low
        stuck3 = 1'b1;
        req1 = 1'b1; addr1 = 3'd3; d1 = 1'b1;
        for (int k = 1; k <= PW + 6; k++) begin
            @(negedge clk);
            if (ack1) req1 = 1'b0;
            chk($sformatf("stuck_err_k%0d", k), err, (k >= PW + 3) ? CHK : 1'b0);
        end
        req1 = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("stuck_err_after_rst", err, 0);
        stuck3 = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Arbitration table, starting from a fresh reset
        do_reset();
        for (int i = 0; i < 5; i++) run_entry(i);

        // Random run against the timeline model
        do_reset();
        m_active = 1'b0; m_p = 0; m_who = 1'b0; m_ptr = 1'b1;
        m_addr = '0; m_d = 1'b0; m_latd = 1'b0;
        pend0 = 1'b0; pend1 = 1'b0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(posedge clk);
            if (m_active) begin
                m_p++;
                if (m_p == PW + 3) m_active = 1'b0;
            end else if (req0 || req1) begin
                g1 = req1 && (!req0 || !m_ptr);
                m_who = g1;
                m_ptr = g1;
                m_addr = g1 ? addr1 : addr0;
                m_d = g1 ? d1 : d0;
                m_latd = m_d;
                m_active = 1'b1;
                m_p = 1;
            end
            @(negedge clk);
            e_latc = (m_active && m_p >= 2 && m_p <= PW + 1) ? (8'h01 << m_addr) : 8'h00;
            chk("rnd_lat_c", lat_c, e_latc);
            chk("rnd_lat_d", lat_d, m_latd);
            chk("rnd_ack0", ack0, 32'(m_active && m_p == PW + 2 && !m_who));
            chk("rnd_ack1", ack1, 32'(m_active && m_p == PW + 2 && m_who));
            chk("rnd_busy", busy, 32'(m_active && m_p <= PW + 2));
            chk("rnd_err", err, 0);

            if (ack0) begin
                req0 = 1'b0; pend0 = 1'b0;
            end else if (!pend0) begin
                if ($urandom_range(0, 2) == 0) begin
                    req0 = 1'b1; pend0 = 1'b1;
                    addr0 = 3'($urandom_range(0, 7)); d0 = 1'($urandom_range(0, 1));
                end
            end else if (req0 && m_active && !m_who && $urandom_range(0, 7) == 0) begin
                req0 = 1'b0;
            end else if (req0 && $urandom_range(0, 3) == 0) begin
                addr0 = 3'($urandom_range(0, 7)); d0 = 1'($urandom_range(0, 1));
            end

            if (ack1) begin
                req1 = 1'b0; pend1 = 1'b0;
            end else if (!pend1) begin
                if ($urandom_range(0, 2) == 0) begin
                    req1 = 1'b1; pend1 = 1'b1;
                    addr1 = 3'($urandom_range(0, 7)); d1 = 1'($urandom_range(0, 1));
                end
            end else if (req1 && m_active && m_who && $urandom_range(0, 7) == 0) begin
                req1 = 1'b0;
            end else if (req1 && $urandom_range(0, 3) == 0) begin
                addr1 = 3'($urandom_range(0, 7)); d1 = 1'($urandom_range(0, 1));
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/latch_bank_sequencer.md
LATCH_BANK_SEQUENCER -- requirements
Module: latch_bank_sequencer

Interface
REQ-001 Parameter PULSE_W, default 2, gate-pulse width in clk cycles; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 req0  input  1  requester 0 write request, held high until ack0.
REQ-005 addr0  input  3  requester 0 target latch index.
REQ-006 d0  input  1  requester 0 write data.
REQ-007 ack0  output  1  requester 0 write-complete pulse.
REQ-008 req1, addr1 (3), d1, ack1  same meaning for requester 1.
REQ-009 lat_d  output  1  shared data line to all eight D latches.
REQ-010 lat_c  output  8  one-hot latch gate; bit i drives latch i enable c.
REQ-011 q_in  input  8  q outputs of the eight latches.
REQ-012 busy  output  1  high whenever FSM is not IDLE.
REQ-013 err  output  1  sticky readback mismatch flag.

Function
REQ-014 FSM states SHALL be IDLE, SETUP, PULSE, HOLD; all outputs registered (Moore).
REQ-015 IDLE: if any req high, grant one requester, capture its addr/d into internal registers, go to SETUP; else stay.
REQ-016 Arbitration SHALL be round-robin: single request wins; both high -> requester not granted last wins; last-granted pointer resets to 1 (requester 0 wins first tie).
REQ-017 SETUP: one cycle, lat_d = captured d, lat_c = 0; go to PULSE.
REQ-018 PULSE: exactly PULSE_W cycles, lat_c = one-hot(captured addr), lat_d unchanged; then HOLD.
REQ-019 HOLD: one cycle, lat_c = 0, lat_d unchanged, ack of granted requester high; then IDLE.
REQ-020 ack0/ack1 SHALL be one-cycle pulses, never both high; lat_c never has more than one bit set.
REQ-021 Latency: req sampled in IDLE at cycle t -> SETUP t+1, PULSE t+2..t+1+PULSE_W, HOLD/ack at t+2+PULSE_W, IDLE t+3+PULSE_W.
REQ-022 At least one IDLE cycle SHALL separate consecutive writes.
REQ-023 req/addr/d changes after grant SHALL be ignored; a granted write always completes and acks even if req drops.
REQ-024 Requests arriving while busy SHALL wait; no request is lost provided req is held.
REQ-025 lat_d SHALL hold its last value in IDLE (no toggling without a write).

Reset
REQ-026 rst_n low SHALL immediately force: state IDLE, lat_c = 0, lat_d = 0, ack0 = ack1 = 0, busy = 0, err = 0, pointer = 1.
REQ-027 Reset during PULSE SHALL drop lat_c asynchronously; the aborted write is not acked and not retried.
REQ-028 After rst_n rises, first write begins no earlier than the first clk edge with rst_n high.

Configuration
REQ-029 Macro LATCH_CHECK_EN: when defined, in HOLD the block compares q_in[captured addr] against captured d and sets err on mismatch; err stays set until reset.
REQ-030 Without LATCH_CHECK_EN, q_in is unused and err is tied to 0; all other behaviour identical.

Verification
REQ-031 Reset: rst_n=0 mid-PULSE -> lat_c=0 same time step, no ack, busy=0, err=0.
REQ-032 Single write, PULSE_W=2: req0=1, addr0=5, d0=1 at t -> lat_d=1 from t+1, lat_c=8'b0010_0000 at t+2..t+3, ack0 at t+4, latch model q[5]=1.
REQ-033 Contention: req0 and req1 high together from reset, addr0=1,d0=0, addr1=6,d1=1 -> requester 0 served first, ack0 then ack1, one IDLE cycle between.
REQ-034 Round-robin: both requesters held continuously for 4 writes -> ack order 0,1,0,1; lat_c never multi-hot.
REQ-035 Mid-op change: after grant, change addr0 to 2 and drop req0 -> write still goes to original address, ack0 still pulses once.
REQ-036 LATCH_CHECK_EN defined, latch model with bit 3 stuck at 0, write d=1 to addr 3 -> err=1 from cycle after HOLD until reset; undefined -> err=0.
